// File: rtl/window_builder_7x7.sv
// Raster-order 7x7 sliding window builder with float32 output packing.
// Six line buffers feed the window's right column; each valid window is converted and registered one cycle after the accept edge.
module window_builder_7x7 #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_valid,
    input  logic [7:0]   pixel_in,
    output logic         de_out,
    output logic [223:0] line_0_out,
    output logic [223:0] line_1_out,
    output logic [223:0] line_2_out,
    output logic [223:0] line_3_out,
    output logic [223:0] line_4_out,
    output logic [223:0] line_5_out,
    output logic [223:0] line_6_out,
    output logic         frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(6);
    localparam logic [RW-1:0] ROW_FIRST = RW'(6);

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [7:0]     line_buf [6][IMG_WIDTH];
    logic [7:0]     win [7][7];
    logic           win_valid;
    logic           win_last;
    logic [6:0][223:0] row_f;

    // Exact 8-bit unsigned to float32: exponent from the leading one, remaining bits left-aligned.
    function automatic logic [31:0] to_f32(input logic [7:0] v);
        logic [2:0]  msb;
        logic [23:0] sh;
        msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) msb = 3'(i);
        end
        sh = {16'd0, v} << (5'd23 - {2'd0, msb});
        return (v == 8'd0) ? 32'd0 : {1'b0, 8'd127 + {5'd0, msb}, sh[22:0]};
    endfunction

    // NOTE: line buffer storage has no reset; its contents are never consumed before being rewritten for the current frame.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int k = 0; k < 5; k++) begin
                line_buf[k][col] <= line_buf[k+1][col];
            end
            line_buf[5][col] <= pixel_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int r = 0; r < 7; r++) begin
                for (int c = 0; c < 7; c++) begin
                    win[r][c] <= 8'd0;
                end
            end
        end else begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (pix_valid) begin
                for (int r = 0; r < 7; r++) begin
                    for (int c = 0; c < 6; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                for (int r = 0; r < 6; r++) begin
                    win[r][6] <= line_buf[r][col];
                end
                win[6][6] <= pixel_in;
                win_valid <= (row >= ROW_FIRST) && (col >= COL_FIRST);
                win_last  <= (row == ROW_LAST) && (col == COL_LAST);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        row_f = '0;
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 7; j++) begin
                row_f[k][223-32*j -: 32] = to_f32(win[k][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_out     <= 1'b0;
            frame_done <= 1'b0;
            line_0_out <= '0;
            line_1_out <= '0;
            line_2_out <= '0;
            line_3_out <= '0;
            line_4_out <= '0;
            line_5_out <= '0;
            line_6_out <= '0;
        end else begin
            de_out     <= win_valid;
            frame_done <= win_last;
            if (win_valid) begin
                line_0_out <= row_f[0];
                line_1_out <= row_f[1];
                line_2_out <= row_f[2];
                line_3_out <= row_f[3];
                line_4_out <= row_f[4];
                line_5_out <= row_f[5];
                line_6_out <= row_f[6];
            end
        end
    end

endmodule

// File: tb/tb_window_builder_7x7.sv
// Scoreboard bench: a 7x7 instance (ramp, gaps, corners, reset) and a default 28x28 instance (two random frames).
module tb_window_builder_7x7;

    typedef struct packed {
        logic [6:0][223:0] lines;
        logic              fd;
        int                cyc;
    } exp_t;

    localparam logic [223:0] RAMP_ROW0 =
        224'h00000000_3F800000_40000000_40400000_40800000_40A00000_40C00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    logic         rst7, pv7, de7, fd7;
    logic [7:0]   px7;
    logic [223:0] l7 [7];
    logic         rst28, pv28, de28, fd28;
    logic [7:0]   px28;
    logic [223:0] l28 [7];

    window_builder_7x7 #(.IMG_WIDTH(7), .IMG_HEIGHT(7)) dut7 (
        .clk(clk), .reset(rst7), .pix_valid(pv7), .pixel_in(px7), .de_out(de7),
        .line_0_out(l7[0]), .line_1_out(l7[1]), .line_2_out(l7[2]), .line_3_out(l7[3]),
        .line_4_out(l7[4]), .line_5_out(l7[5]), .line_6_out(l7[6]), .frame_done(fd7)
    );

    window_builder_7x7 dut28 (
        .clk(clk), .reset(rst28), .pix_valid(pv28), .pixel_in(px28), .de_out(de28),
        .line_0_out(l28[0]), .line_1_out(l28[1]), .line_2_out(l28[2]), .line_3_out(l28[3]),
        .line_4_out(l28[4]), .line_5_out(l28[5]), .line_6_out(l28[6]), .frame_done(fd28)
    );

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference conversion via the simulator's double-precision encoding.
    function automatic logic [31:0] ref_f32(input int v);
        logic [63:0] d;
        logic [10:0] e;
        if (v == 0) return 32'd0;
        d = $realtobits(real'(v));
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // ---------------- 7x7 model and driver ----------------
    exp_t q7[$];
    int   img7 [7][7];
    int   r7 = 0, c7 = 0;
    int   de7_cnt = 0;
    logic [223:0] last7 [7];

    task automatic push7(input logic [7:0] v);
        exp_t e;
        img7[r7][c7] = v;
        if (r7 >= 6 && c7 >= 6) begin
            e.lines = '0;
            for (int k = 0; k < 7; k++)
                for (int j = 0; j < 7; j++)
                    e.lines[k][223-32*j -: 32] = ref_f32(img7[r7-6+k][c7-6+j]);
            e.fd  = (r7 == 6) && (c7 == 6);
            e.cyc = cyc + 2;
            q7.push_back(e);
        end
        pv7 = 1'b1;
        px7 = v;
        @(negedge clk);
        pv7 = 1'b0;
        px7 = $urandom_range(0, 255);
        if (c7 == 6) begin
            c7 = 0;
            r7 = (r7 == 6) ? 0 : r7 + 1;
        end else begin
            c7 = c7 + 1;
        end
    endtask

    task automatic idle7(input int n);
        pv7 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // mode 0: ramp, 1: ramp with random gaps, 2: random with conversion corners at top-left
    task automatic frame7(input int mode);
        logic [7:0] v;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                v = 8'(r * 7 + c);
                if (mode == 2) begin
                    v = 8'($urandom_range(0, 255));
                    if (r == 0 && c == 0) v = 8'd1;
                    if (r == 0 && c == 1) v = 8'd7;
                    if (r == 0 && c == 2) v = 8'd128;
                    if (r == 0 && c == 3) v = 8'd255;
                end
                if (mode == 1 && $urandom_range(0, 1) == 1) idle7($urandom_range(1, 3));
                push7(v);
            end
        end
    endtask

    task automatic check_ramp_window(input string tag);
        check({tag, "_line0"}, last7[0], RAMP_ROW0);
        check({tag, "_line6_left"}, {192'd0, last7[6][223:192]}, 224'h42280000);
        check({tag, "_line6_right"}, {192'd0, last7[6][31:0]}, 224'h42400000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (de7) begin
            de7_cnt++;
            if (q7.size() == 0) begin
                check("w7_unexpected_de", {223'd0, de7}, 224'd0);
            end else begin
                e = q7.pop_front();
                for (int k = 0; k < 7; k++) check($sformatf("w7_line%0d", k), l7[k], e.lines[k]);
                check("w7_frame_done", {223'd0, fd7}, {223'd0, e.fd});
                check("w7_latency", 224'(cyc), 224'(e.cyc));
            end
            last7 = l7;
        end else begin
            check("w7_fd_idle", {223'd0, fd7}, 224'd0);
            for (int k = 0; k < 7; k++) check($sformatf("w7_hold%0d", k), l7[k], last7[k]);
        end
    end

    // ---------------- 28x28 model and driver ----------------
    exp_t q28[$];
    int   img28 [28][28];
    int   de28_cnt = 0, fd28_cnt = 0;
    int   de_at_fd [4];

    task automatic push28(input int r, input int c, input logic [7:0] v);
        exp_t e;
        img28[r][c] = v;
        if (r >= 6 && c >= 6) begin
            e.lines = '0;
            for (int k = 0; k < 7; k++)
                for (int j = 0; j < 7; j++)
                    e.lines[k][223-32*j -: 32] = ref_f32(img28[r-6+k][c-6+j]);
            e.fd  = (r == 27) && (c == 27);
            e.cyc = cyc + 2;
            q28.push_back(e);
        end
        pv28 = 1'b1;
        px28 = v;
        @(negedge clk);
        pv28 = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (de28) begin
            de28_cnt++;
            if (q28.size() == 0) begin
                check("w28_unexpected_de", {223'd0, de28}, 224'd0);
            end else begin
                e = q28.pop_front();
                for (int k = 0; k < 7; k++) check($sformatf("w28_line%0d", k), l28[k], e.lines[k]);
                check("w28_frame_done", {223'd0, fd28}, {223'd0, e.fd});
                check("w28_latency", 224'(cyc), 224'(e.cyc));
            end
        end else begin
            check("w28_fd_idle", {223'd0, fd28}, 224'd0);
        end
        if (fd28) begin
            if (fd28_cnt < 4) de_at_fd[fd28_cnt] = de28_cnt;
            fd28_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst7 = 1'b0; rst28 = 1'b0;
        pv7 = 1'b0; pv28 = 1'b0; px7 = 8'd0; px28 = 8'd0;
        for (int k = 0; k < 7; k++) last7[k] = '0;
        #12;
        check("reset_de7", {223'd0, de7}, 224'd0);
        check("reset_fd7", {223'd0, fd7}, 224'd0);
        for (int k = 0; k < 7; k++) check($sformatf("reset_line%0d", k), l7[k], 224'd0);
        check("reset_de28", {223'd0, de28}, 224'd0);
        @(negedge clk);
        rst7 = 1'b1; rst28 = 1'b1;

        fork
            begin
                frame7(0);
                idle7(4);
                check("ramp_de_count", 224'(de7_cnt), 224'd1);
                check_ramp_window("ramp");

                frame7(1);
                idle7(4);
                check("gap_de_count", 224'(de7_cnt), 224'd2);
                check_ramp_window("gap");

                frame7(2);
                idle7(4);
                check("corner_1",   {192'd0, last7[0][223:192]}, 224'h3F800000);
                check("corner_7",   {192'd0, last7[0][191:160]}, 224'h40E00000);
                check("corner_128", {192'd0, last7[0][159:128]}, 224'h43000000);
                check("corner_255", {192'd0, last7[0][127:96]},  224'h437F0000);

                for (int i = 0; i < 20; i++) push7(8'(i));
                @(posedge clk);
                #2 rst7 = 1'b0;
                #1;
                check("midrst_de", {223'd0, de7}, 224'd0);
                check("midrst_fd", {223'd0, fd7}, 224'd0);
                for (int k = 0; k < 7; k++) check($sformatf("midrst_line%0d", k), l7[k], 224'd0);
                for (int k = 0; k < 7; k++) last7[k] = '0;
                check("midrst_queue_empty", 224'(q7.size()), 224'd0);
                r7 = 0;
                c7 = 0;
                @(negedge clk);
                rst7 = 1'b1;
                frame7(0);
                idle7(4);
                check("post_rst_de_count", 224'(de7_cnt), 224'd4);
                check_ramp_window("post_rst");
                check("q7_drained", 224'(q7.size()), 224'd0);
            end
            begin
                for (int f = 0; f < 2; f++)
                    for (int r = 0; r < 28; r++)
                        for (int c = 0; c < 28; c++)
                            push28(r, c, 8'($urandom_range(0, 255)));
                repeat (4) @(negedge clk);
                check("w28_total_de", 224'(de28_cnt), 224'd968);
                check("w28_total_fd", 224'(fd28_cnt), 224'd2);
                check("w28_frame1_de", 224'(de_at_fd[0]), 224'd484);
                check("w28_frame2_de", 224'(de_at_fd[1]), 224'd968);
                check("q28_drained", 224'(q28.size()), 224'd0);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
